// File: rtl/axis_sync_fifo_pkg.sv
// axis_sync_fifo_pkg: shared AXI-Stream constants, beat type and helpers
package axis_sync_fifo_pkg;
  localparam int AXIS_TDATA_WIDTH_DEF = 32;
  typedef struct packed {
    logic [AXIS_TDATA_WIDTH_DEF-1:0] tdata;
    logic                            tvalid;
    logic                            tready;
  } axis_beat_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/axis_sync_fifo_if.sv
// axis_sync_fifo_if: AXI-Stream handshake bundle
// master drives tdata/tvalid and samples tready; slave is the mirror
interface axis_sync_fifo_if
  import axis_sync_fifo_pkg::*;
#(
  parameter int W = AXIS_TDATA_WIDTH_DEF
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  modport master (output tdata, output tvalid, input tready);
  modport slave (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_sync_fifo_sat_counter.sv
// axis_sync_fifo_sat_counter: saturating counter, clear wins over enable
// clk/rst: clock and sync active-high reset; clr_i: clear; en_i: count; cnt_o: value
module axis_sync_fifo_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock FWFT AXI-Stream FIFO with fill/almost-full/stall monitors
// s_axis_aclk/rst: clock, sync active-high reset; S_AXIS: input stream; M_AXIS: output stream
// fill_level: occupancy; almost_full: fill_level >= ALMOST_FULL_LEVEL
// stall_count: saturating count of refused input cycles; stall_clear: clears it
module axis_sync_fifo
  import axis_sync_fifo_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH  = AXIS_TDATA_WIDTH_DEF,
  parameter int DEPTH_LOG2        = 4,
  parameter int ALMOST_FULL_LEVEL = 12,
  parameter int STALL_CNT_WIDTH   = 16
) (
  input  logic                       s_axis_aclk,
  input  logic                       rst,
  axis_sync_fifo_if.slave            S_AXIS,
  axis_sync_fifo_if.master           M_AXIS,
  output logic [DEPTH_LOG2:0]        fill_level,
  output logic                       almost_full,
  output logic [STALL_CNT_WIDTH-1:0] stall_count,
  input  logic                       stall_clear
);
  localparam int AW = DEPTH_LOG2;
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_LVL = ALMOST_FULL_LEVEL[AW:0];
  logic [AXIS_TDATA_WIDTH-1:0] mem_q [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic s_tready_q, m_tvalid_q, almost_full_q;
  logic [AXIS_TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic push, pop;
  assign push = S_AXIS.tvalid & s_tready_q;
  assign pop  = m_tvalid_q & M_AXIS.tready;
  // The next head is the word being written this cycle when the FIFO would
  // otherwise be empty after the pop; this gives 1-cycle latency and no bubble.
  always_comb begin
    count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    wr_ptr_d  = wr_ptr_q + {{(AW-1){1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{(AW-1){1'b0}}, pop};
    m_tdata_d = (push && count_q == {{AW{1'b0}}, pop}) ? S_AXIS.tdata : mem_q[rd_ptr_d];
  end
  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      s_tready_q    <= 1'b0;
      m_tvalid_q    <= 1'b0;
      m_tdata_q     <= '0;
      almost_full_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      s_tready_q    <= count_d != FULL;
      m_tvalid_q    <= count_d != '0;
      m_tdata_q     <= m_tdata_d;
      almost_full_q <= count_d >= AF_LVL;
    end
  end
  always_ff @(posedge s_axis_aclk) if (push) mem_q[wr_ptr_q] <= S_AXIS.tdata;
  axis_sync_fifo_sat_counter #(.W(STALL_CNT_WIDTH)) u_stall (
    .clk   (s_axis_aclk),
    .rst   (rst),
    .clr_i (stall_clear),
    .en_i  (S_AXIS.tvalid & ~s_tready_q),
    .cnt_o (stall_count)
  );
  assign S_AXIS.tready = s_tready_q;
  assign M_AXIS.tvalid = m_tvalid_q;
  assign M_AXIS.tdata  = m_tdata_q;
  assign fill_level    = count_q;
  assign almost_full   = almost_full_q;
endmodule

// File: tb/tb_axis_sync_fifo.sv
// tb_axis_sync_fifo: queue-model checked bench for axis_sync_fifo
module tb_axis_sync_fifo;
  localparam int W = 32, AW = 4, DEPTH = 16, AFL = 12, SW = 4;
  logic clk = 0, rst = 1, stall_clear = 0;
  logic [AW:0] fill_level;
  logic almost_full;
  logic [SW-1:0] stall_count;
  axis_sync_fifo_if #(.W(W)) s_if ();
  axis_sync_fifo_if #(.W(W)) m_if ();
  always #5 clk = ~clk;
  axis_sync_fifo #(
    .AXIS_TDATA_WIDTH(W), .DEPTH_LOG2(AW), .ALMOST_FULL_LEVEL(AFL), .STALL_CNT_WIDTH(SW)
  ) dut (
    .s_axis_aclk(clk), .rst(rst), .S_AXIS(s_if), .M_AXIS(m_if),
    .fill_level(fill_level), .almost_full(almost_full),
    .stall_count(stall_count), .stall_clear(stall_clear)
  );
  int checks = 0, failures = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] dut_out[$];
  int mstall = 0;
  bit mrst = 1, armed = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Reference model: a plain queue, a reset-state flag and a saturating integer.
  always @(posedge clk) begin
    bit tr, tv, pu, po;
    if (rst) begin
      mq.delete();
      mstall = 0;
      mrst = 1;
      armed = 1;
    end else begin
      tr = !mrst && mq.size() != DEPTH;
      tv = !mrst && mq.size() != 0;
      pu = s_if.tvalid && tr;
      po = tv && m_if.tready;
      if (po) dut_out.push_back(m_if.tdata);
      if (stall_clear) mstall = 0;
      else if (s_if.tvalid && !tr && mstall != (1 << SW) - 1) mstall++;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(s_if.tdata);
      mrst = 0;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("m_tready_s", s_if.tready, !mrst && mq.size() != DEPTH);
      chk("m_tvalid", m_if.tvalid, !mrst && mq.size() != 0);
      chk("m_fill", fill_level, mq.size());
      chk("m_afull", almost_full, mq.size() >= AFL);
      chk("m_stall", stall_count, mstall);
      if (mrst) chk("m_tdata_rst", m_if.tdata, 0);
      else if (mq.size() != 0) chk("m_tdata", m_if.tdata, mq[0]);
    end
  end
  task automatic drain();
    int n = 0;
    s_if.tvalid = 0;
    m_if.tready = 1;
    while (m_if.tvalid && n < 40) begin
      step();
      n++;
    end
    m_if.tready = 0;
    chk("drain_empty", m_if.tvalid, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int idx, cyc;
    bit pushed;
    s_if.tvalid = 0;
    s_if.tdata = 0;
    m_if.tready = 0;
    repeat (3) step();
    chk("rst_tready", s_if.tready, 0);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_tdata", m_if.tdata, 0);
    rst = 0;
    step();
    chk("rel_tready", s_if.tready, 1);
    chk("rel_tvalid", m_if.tvalid, 0);
    chk("rel_fill", fill_level, 0);
    chk("rel_stall", stall_count, 0);
    s_if.tvalid = 1;
    s_if.tdata = 32'hDEADBEEF;
    step();
    s_if.tvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("lat_tvalid", m_if.tvalid, 1);
      chk("lat_tdata", m_if.tdata, 32'hDEADBEEF);
      chk("lat_fill", fill_level, 1);
      if (i < 4) step();
    end
    m_if.tready = 1;
    step();
    m_if.tready = 0;
    chk("pop1_fill", fill_level, 0);
    dut_out.delete();
    for (int i = 0; i < 20; i++) begin
      s_if.tvalid = 1;
      s_if.tdata = W'(i);
      step();
      if (i == 10) chk("af_at11", almost_full, 0);
      if (i == 11) chk("af_at12", almost_full, 1);
      if (i == 14) chk("tready_at15", s_if.tready, 1);
      if (i == 15) chk("tready_full", s_if.tready, 0);
    end
    chk("full_fill", fill_level, 16);
    chk("full_stall", stall_count, 4);
    chk("full_tready", s_if.tready, 0);
    s_if.tdata = 32'd20;
    m_if.tready = 1;
    step();
    s_if.tvalid = 0;
    m_if.tready = 0;
    chk("fpop_fill", fill_level, 15);
    chk("fpop_tready", s_if.tready, 1);
    chk("fpop_count", dut_out.size(), 1);
    chk("fpop_word", dut_out[0], 0);
    chk("fpop_head", m_if.tdata, 1);
    drain();
    dut_out.delete();
    idx = 0;
    cyc = 0;
    while (dut_out.size() < 100 && cyc < 3000) begin
      s_if.tvalid = idx < 100;
      s_if.tdata = W'(idx);
      m_if.tready = 1'($urandom_range(0, 1));
      pushed = s_if.tvalid && s_if.tready;
      step();
      if (pushed) idx++;
      cyc++;
    end
    s_if.tvalid = 0;
    m_if.tready = 0;
    chk("stream_len", dut_out.size(), 100);
    for (int i = 0; i < 100 && i < dut_out.size(); i++) chk("stream_word", dut_out[i], W'(i));
    drain();
    for (int i = 0; i < 7; i++) begin
      s_if.tvalid = 1;
      s_if.tdata = W'(100 + i);
      step();
    end
    s_if.tvalid = 0;
    chk("hold7_fill", fill_level, 7);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_tvalid", m_if.tvalid, 0);
    chk("mrst_fill", fill_level, 0);
    step();
    for (int i = 0; i < 36; i++) begin
      s_if.tvalid = 1;
      s_if.tdata = W'(200 + i);
      step();
    end
    chk("sat_stall", stall_count, 15);
    s_if.tvalid = 0;
    stall_clear = 1;
    step();
    stall_clear = 0;
    chk("clr_stall", stall_count, 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
